// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending-write counters that stall decode
// on RAW hazards and on counter saturation; writeback retires entries.
// Ports:
//   CLK, nRST                  clock, async active-low reset
//   issue_*                    decode-side instruction (sources, dest, valid)
//   wb_valid, wb_rd            register file write port activity
//   flush                      discard all in-flight writes
//   issue_ack, stall           combinational accept / hold decode
//   pending_mask               bit r set while reg r has in-flight writes
//   err_underflow              sticky: writeback with no pending write
module regfile_scoreboard #(
    parameter int NREGS     = 32,
    parameter int CNT_W     = 2,
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             issue_valid,
    input  logic [4:0]       issue_rs,
    input  logic [4:0]       issue_rt,
    input  logic             issue_use_rs,
    input  logic             issue_use_rt,
    input  logic             issue_wen,
    input  logic [4:0]       issue_rd,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    input  logic             flush,
    output logic             issue_ack,
    output logic             stall,
    output logic [NREGS-1:0] pending_mask,
    output logic             err_underflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] pend_q [NREGS];
    logic [CNT_W-1:0] pend_d [NREGS];
    logic             err_q;
    logic             err_d;
    logic [NREGS-1:0] busy;
    logic             hazard;
    logic             sat;
    logic             inc_en;
    logic             dec_en;
    logic             under;

    // A source is busy while writes are pending, unless the last one
    // is being written back this very cycle (bypass).
    always_comb begin
        busy = '0;
        for (int r = 1; r < NREGS; r++) begin
            busy[r] = (pend_q[r] != '0) &&
                      !(WB_BYPASS && wb_valid &&
                        (wb_rd == 5'(r)) && (pend_q[r] == CNT_ONE));
        end
    end

    assign sat    = issue_wen && (issue_rd != 5'd0) &&
                    (pend_q[issue_rd] == CNT_MAX);
    assign hazard = (issue_use_rs && busy[issue_rs]) ||
                    (issue_use_rt && busy[issue_rt]) || sat;

    assign issue_ack = issue_valid && !hazard && !flush;
    assign stall     = issue_valid && hazard && !flush;

    assign inc_en = issue_ack && issue_wen && (issue_rd != 5'd0);
    assign dec_en = wb_valid && (wb_rd != 5'd0);
    assign under  = dec_en && (pend_q[wb_rd] == '0);

    always_comb begin
        pend_d[0] = '0;
        for (int r = 1; r < NREGS; r++) begin
            pend_d[r] = pend_q[r];
            if (flush) begin
                pend_d[r] = '0;
            end else if (inc_en && (issue_rd == 5'(r)) &&
                         !(dec_en && (wb_rd == 5'(r)))) begin
                pend_d[r] = pend_q[r] + CNT_ONE;
            end else if (dec_en && (wb_rd == 5'(r)) &&
                         !(inc_en && (issue_rd == 5'(r))) &&
                         (pend_q[r] != '0)) begin
                pend_d[r] = pend_q[r] - CNT_ONE;
            end
        end
    end

    assign err_d = err_q || (!flush && under);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int r = 0; r < NREGS; r++) begin
                pend_q[r] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                pend_q[r] <= pend_d[r];
            end
            err_q <= err_d;
        end
    end

    always_comb begin
        pending_mask = '0;
        for (int r = 0; r < NREGS; r++) begin
            pending_mask[r] = (pend_q[r] != '0);
        end
    end

    assign err_underflow = err_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: vector table plus hand sequences for the
// register file scoreboard (bypass and non-bypass instances).
module tb_regfile_scoreboard;

    logic        CLK;
    logic        nRST;
    logic        issue_valid;
    logic [4:0]  issue_rs;
    logic [4:0]  issue_rt;
    logic        issue_use_rs;
    logic        issue_use_rt;
    logic        issue_wen;
    logic [4:0]  issue_rd;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        flush;
    logic        issue_ack;
    logic        stall;
    logic [31:0] pending_mask;
    logic        err_underflow;
    logic        ack0;
    logic        stall0;
    logic [31:0] mask0;
    logic        err0;

    int checks = 0;
    int errors = 0;

    regfile_scoreboard #(.NREGS(32), .CNT_W(2), .WB_BYPASS(1'b1)) dut (
        .CLK(CLK), .nRST(nRST),
        .issue_valid(issue_valid), .issue_rs(issue_rs),
        .issue_rt(issue_rt), .issue_use_rs(issue_use_rs),
        .issue_use_rt(issue_use_rt), .issue_wen(issue_wen),
        .issue_rd(issue_rd), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .flush(flush), .issue_ack(issue_ack), .stall(stall),
        .pending_mask(pending_mask), .err_underflow(err_underflow)
    );

    regfile_scoreboard #(.NREGS(32), .CNT_W(2), .WB_BYPASS(1'b0)) dut0 (
        .CLK(CLK), .nRST(nRST),
        .issue_valid(issue_valid), .issue_rs(issue_rs),
        .issue_rt(issue_rt), .issue_use_rs(issue_use_rs),
        .issue_use_rt(issue_use_rt), .issue_wen(issue_wen),
        .issue_rd(issue_rd), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .flush(flush), .issue_ack(ack0), .stall(stall0),
        .pending_mask(mask0), .err_underflow(err0)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        valid;
        logic [4:0]  rs;
        logic        urs;
        logic [4:0]  rt;
        logic        urt;
        logic        wen;
        logic [4:0]  rd;
        logic        wb;
        logic [4:0]  wbrd;
        logic        fl;
        logic        ack;
        logic        stl;
        logic [31:0] mask;
        logic        err;
    } vec_t;

    typedef struct {
        logic [31:0] mask;
        logic        err;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    function automatic vec_t v(input int valid, input int rs, input int urs,
                               input int rt, input int urt, input int wen,
                               input int rd, input int wb, input int wbrd,
                               input int fl, input int ack, input int stl,
                               input logic [31:0] mask, input int err);
        vec_t x;
        x.valid = 1'(valid); x.rs = 5'(rs); x.urs = 1'(urs);
        x.rt = 5'(rt); x.urt = 1'(urt); x.wen = 1'(wen);
        x.rd = 5'(rd); x.wb = 1'(wb); x.wbrd = 5'(wbrd);
        x.fl = 1'(fl); x.ack = 1'(ack); x.stl = 1'(stl);
        x.mask = mask; x.err = 1'(err);
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t x);
        issue_valid  = x.valid;
        issue_rs     = x.rs;
        issue_use_rs = x.urs;
        issue_rt     = x.rt;
        issue_use_rt = x.urt;
        issue_wen    = x.wen;
        issue_rd     = x.rd;
        wb_valid     = x.wb;
        wb_rd        = x.wbrd;
        flush        = x.fl;
    endtask

    task automatic apply(input vec_t x, input int idx);
        exp_t e;
        drive(x);
        #2;
        chk($sformatf("ack[%0d]", idx), 32'(issue_ack), 32'(x.ack));
        chk($sformatf("stall[%0d]", idx), 32'(stall), 32'(x.stl));
        e.mask = x.mask;
        e.err  = x.err;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        e = sb.pop_front();
        chk($sformatf("mask[%0d]", idx), pending_mask, e.mask);
        chk($sformatf("err[%0d]", idx), 32'(err_underflow), 32'(e.err));
        @(negedge CLK);
    endtask

    task automatic idle();
        drive(v(0,0,0,0,0,0,0,0,0,0,0,0,32'h0,0));
    endtask

    initial begin
        // RAW with bypass
        tbl.push_back(v(1,0,0,0,0,1,3, 0,0,0, 1,0,32'h8,0));
        tbl.push_back(v(1,3,1,0,0,0,0, 0,0,0, 0,1,32'h8,0));
        tbl.push_back(v(1,3,1,0,0,0,0, 0,0,0, 0,1,32'h8,0));
        tbl.push_back(v(1,3,1,0,0,0,0, 1,3,0, 1,0,32'h0,0));
        // simultaneous issue and writeback on r7
        tbl.push_back(v(1,0,0,0,0,1,7, 0,0,0, 1,0,32'h80,0));
        tbl.push_back(v(1,0,0,0,0,1,7, 1,7,0, 1,0,32'h80,0));
        tbl.push_back(v(0,0,0,0,0,0,0, 1,7,0, 0,0,32'h0,0));
        // saturation on r9
        tbl.push_back(v(1,0,0,0,0,1,9, 0,0,0, 1,0,32'h200,0));
        tbl.push_back(v(1,0,0,0,0,1,9, 0,0,0, 1,0,32'h200,0));
        tbl.push_back(v(1,0,0,0,0,1,9, 0,0,0, 1,0,32'h200,0));
        tbl.push_back(v(1,0,0,0,0,1,9, 0,0,0, 0,1,32'h200,0));
        tbl.push_back(v(1,0,0,0,0,1,9, 1,9,0, 0,1,32'h200,0));
        tbl.push_back(v(1,0,0,0,0,1,9, 0,0,0, 1,0,32'h200,0));
        tbl.push_back(v(0,0,0,0,0,0,0, 1,9,0, 0,0,32'h200,0));
        tbl.push_back(v(0,0,0,0,0,0,0, 1,9,0, 0,0,32'h200,0));
        tbl.push_back(v(0,0,0,0,0,0,0, 1,9,0, 0,0,32'h0,0));
        // rt hazard, unused source ignored
        tbl.push_back(v(1,0,0,0,0,1,12, 0,0,0, 1,0,32'h1000,0));
        tbl.push_back(v(1,0,0,12,1,0,0, 0,0,0, 0,1,32'h1000,0));
        tbl.push_back(v(1,12,0,0,1,0,0, 0,0,0, 1,0,32'h1000,0));
        tbl.push_back(v(0,0,0,0,0,0,0, 1,12,0, 0,0,32'h0,0));
        // register 0
        tbl.push_back(v(1,0,0,0,0,1,0, 0,0,0, 1,0,32'h0,0));
        tbl.push_back(v(1,0,1,0,1,0,0, 0,0,0, 1,0,32'h0,0));
        tbl.push_back(v(0,0,0,0,0,0,0, 1,0,0, 0,0,32'h0,0));
        // flush, then underflow
        tbl.push_back(v(1,0,0,0,0,1,4, 0,0,0, 1,0,32'h10,0));
        tbl.push_back(v(1,0,0,0,0,1,6, 0,0,0, 1,0,32'h50,0));
        tbl.push_back(v(1,0,0,0,0,1,6, 0,0,0, 1,0,32'h50,0));
        tbl.push_back(v(1,0,0,0,0,1,8, 1,4,1, 0,0,32'h0,0));
        tbl.push_back(v(0,0,0,0,0,0,0, 1,4,0, 0,0,32'h0,1));
        tbl.push_back(v(0,0,0,0,0,0,0, 0,0,0, 0,0,32'h0,1));

        nRST = 1'b0;
        idle();
        issue_valid = 1'b1;
        #2;
        chk("rst_mask", pending_mask, 32'h0);
        chk("rst_err", 32'(err_underflow), 32'h0);
        chk("rst_ack", 32'(issue_ack), 32'h1);
        chk("rst_stall", 32'(stall), 32'h0);
        idle();
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);

        foreach (tbl[i]) apply(tbl[i], i);

        // mid-run reset with pend[5]=2 and err set
        apply(v(1,0,0,0,0,1,5, 0,0,0, 1,0,32'h20,1), 100);
        apply(v(1,0,0,0,0,1,5, 0,0,0, 1,0,32'h20,1), 101);
        idle();
        #2;
        nRST = 1'b0;
        #1;
        chk("midrst_mask", pending_mask, 32'h0);
        chk("midrst_err", 32'(err_underflow), 32'h0);
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);
        // reg 5 no longer busy after reset
        apply(v(1,5,1,0,0,0,0, 0,0,0, 1,0,32'h0,0), 102);

        // no-bypass instance: ack one cycle after writeback
        apply(v(1,0,0,0,0,1,3, 0,0,0, 1,0,32'h8,0), 110);
        drive(v(1,3,1,0,0,0,0, 1,3,0, 0,0,32'h0,0));
        #2;
        chk("nobyp_stall_wb", 32'(stall0), 32'h1);
        chk("nobyp_ack_wb", 32'(ack0), 32'h0);
        chk("byp_ack_wb", 32'(issue_ack), 32'h1);
        @(posedge CLK);
        #1;
        chk("nobyp_mask", mask0, 32'h0);
        @(negedge CLK);
        drive(v(1,3,1,0,0,0,0, 0,0,0, 0,0,32'h0,0));
        #2;
        chk("nobyp_ack_next", 32'(ack0), 32'h1);
        chk("nobyp_stall_next", 32'(stall0), 32'h0);
        @(negedge CLK);
        idle();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
